// File: rtl/ppt_regfile_pkg.sv
// Shared register map, bit positions, reset defaults and FSM state types for ppt_regfile.
package ppt_regfile_pkg;

  localparam logic [3:0] OFF_CLK_DIV  = 4'h0;
  localparam logic [3:0] OFF_PERIOD_L = 4'h1;
  localparam logic [3:0] OFF_PERIOD_H = 4'h2;
  localparam logic [3:0] OFF_WIDTH_L  = 4'h3;
  localparam logic [3:0] OFF_WIDTH_H  = 4'h4;
  localparam logic [3:0] OFF_COUNT_L  = 4'h5;
  localparam logic [3:0] OFF_COUNT_H  = 4'h6;
  localparam logic [3:0] OFF_CTRL     = 4'h7;
  localparam logic [3:0] OFF_CDONE_L  = 4'h8;
  localparam logic [3:0] OFF_CDONE_H  = 4'h9;
  localparam logic [3:0] OFF_STATUS   = 4'hA;

  localparam int CTRL_RUN     = 0;
  localparam int CTRL_COMMIT  = 1;
  localparam int CTRL_IE      = 2;
  localparam int STAT_DONE    = 0;
  localparam int STAT_STICKY  = 1;
  localparam int STAT_PENDING = 2;

  localparam logic [4:0]  RST_CLK_DIV = 5'd9;
  localparam int unsigned RST_PERIOD  = 128;
  localparam int unsigned RST_WIDTH   = 1;
  localparam int unsigned RST_COUNT   = 16;

  typedef enum logic {CM_IDLE, CM_PENDING} commit_state_t;
  typedef enum logic {INIT_S, READY_S} init_state_t;

endpackage

// File: rtl/ppt_regfile_channel.sv
// One PPT channel: shadow/live configuration, deferred commit FSM, status capture.
// Sticky DONE, IE and interrupt request exist only when PPT_REGFILE_IRQ_EN is defined.
module ppt_regfile_channel
  import ppt_regfile_pkg::*;
#(
  parameter int PW = 14,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [3:0]    offset_i,
  input  logic          wr_i,
  input  logic [7:0]    wdata_i,
  input  logic          init_load_i,
  input  logic          run_init_i,
  input  logic [CW-1:0] count_done_i,
  input  logic          done_i,
  output logic [7:0]    rdata_o,
  output logic [4:0]    clk_div_o,
  output logic [PW-1:0] period_o,
  output logic [PW-1:0] width_o,
  output logic [CW-1:0] count_o,
  output logic          run_o,
  output logic          irq_o
);

  logic [4:0]    cdiv_sh_q, cdiv_sh_d, cdiv_lv_q, cdiv_lv_d;
  logic [PW-1:0] per_sh_q, per_sh_d, per_lv_q, per_lv_d;
  logic [PW-1:0] wid_sh_q, wid_sh_d, wid_lv_q, wid_lv_d;
  logic [CW-1:0] cnt_sh_q, cnt_sh_d, cnt_lv_q, cnt_lv_d;
  logic [CW-1:0] cd_q, cd_d;
  logic          run_q, run_d;
  logic          done_q, done_d;
  commit_state_t state_q, state_d;

  logic          commit_wr;
  logic          ie_bit, sticky_bit;
  logic [15:0]   per_ext, wid_ext, cnt_ext, cd_ext;

  // Zero-extended views give uniform byte access for any PW/CW in range.
  assign per_ext = 16'(per_sh_q);
  assign wid_ext = 16'(wid_sh_q);
  assign cnt_ext = 16'(cnt_sh_q);
  assign cd_ext  = 16'(cd_q);

  assign commit_wr = wr_i && (offset_i == OFF_CTRL) && wdata_i[CTRL_COMMIT];

`ifdef PPT_REGFILE_IRQ_EN
  logic ie_q, ie_d, sticky_q, sticky_d;
  assign ie_bit     = ie_q;
  assign sticky_bit = sticky_q;
  assign irq_o      = ie_q & sticky_q;
`else
  assign ie_bit     = 1'b0;
  assign sticky_bit = 1'b0;
  assign irq_o      = 1'b0;
`endif

  always_comb begin
    cdiv_sh_d = cdiv_sh_q;
    per_sh_d  = per_sh_q;
    wid_sh_d  = wid_sh_q;
    cnt_sh_d  = cnt_sh_q;
    cdiv_lv_d = cdiv_lv_q;
    per_lv_d  = per_lv_q;
    wid_lv_d  = wid_lv_q;
    cnt_lv_d  = cnt_lv_q;
    run_d     = run_q;
    state_d   = state_q;
    cd_d      = count_done_i;
    done_d    = done_i;
`ifdef PPT_REGFILE_IRQ_EN
    ie_d      = ie_q;
    sticky_d  = sticky_q;
`endif

    if (init_load_i) run_d = run_init_i;

    if (wr_i) begin
      case (offset_i)
        OFF_CLK_DIV:  cdiv_sh_d = wdata_i[4:0];
        OFF_PERIOD_L: per_sh_d  = PW'({per_ext[15:8], wdata_i});
        OFF_PERIOD_H: per_sh_d  = PW'({wdata_i, per_ext[7:0]});
        OFF_WIDTH_L:  wid_sh_d  = PW'({wid_ext[15:8], wdata_i});
        OFF_WIDTH_H:  wid_sh_d  = PW'({wdata_i, wid_ext[7:0]});
        OFF_COUNT_L:  cnt_sh_d  = CW'({cnt_ext[15:8], wdata_i});
        OFF_COUNT_H:  cnt_sh_d  = CW'({wdata_i, cnt_ext[7:0]});
        OFF_CTRL: begin
          run_d = wdata_i[CTRL_RUN];
`ifdef PPT_REGFILE_IRQ_EN
          ie_d  = wdata_i[CTRL_IE];
`endif
        end
`ifdef PPT_REGFILE_IRQ_EN
        OFF_STATUS: if (wdata_i[STAT_STICKY]) sticky_d = 1'b0;
`endif
        default: ;
      endcase
    end

`ifdef PPT_REGFILE_IRQ_EN
    // A new rising edge outranks a W1C clear landing in the same cycle.
    if (done_i && !done_q) sticky_d = 1'b1;
`endif

    case (state_q)
      CM_IDLE: if (commit_wr) state_d = CM_PENDING;
      CM_PENDING: begin
        if (!run_q || done_i) begin
          cdiv_lv_d = cdiv_sh_q;
          per_lv_d  = per_sh_q;
          wid_lv_d  = wid_sh_q;
          cnt_lv_d  = cnt_sh_q;
          state_d   = commit_wr ? CM_PENDING : CM_IDLE;
        end
      end
      default: state_d = CM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cdiv_sh_q <= RST_CLK_DIV;
      per_sh_q  <= PW'(RST_PERIOD);
      wid_sh_q  <= PW'(RST_WIDTH);
      cnt_sh_q  <= CW'(RST_COUNT);
      cdiv_lv_q <= RST_CLK_DIV;
      per_lv_q  <= PW'(RST_PERIOD);
      wid_lv_q  <= PW'(RST_WIDTH);
      cnt_lv_q  <= CW'(RST_COUNT);
      run_q     <= 1'b0;
      state_q   <= CM_IDLE;
      cd_q      <= '0;
      done_q    <= 1'b0;
`ifdef PPT_REGFILE_IRQ_EN
      ie_q      <= 1'b0;
      sticky_q  <= 1'b0;
`endif
    end else begin
      cdiv_sh_q <= cdiv_sh_d;
      per_sh_q  <= per_sh_d;
      wid_sh_q  <= wid_sh_d;
      cnt_sh_q  <= cnt_sh_d;
      cdiv_lv_q <= cdiv_lv_d;
      per_lv_q  <= per_lv_d;
      wid_lv_q  <= wid_lv_d;
      cnt_lv_q  <= cnt_lv_d;
      run_q     <= run_d;
      state_q   <= state_d;
      cd_q      <= cd_d;
      done_q    <= done_d;
`ifdef PPT_REGFILE_IRQ_EN
      ie_q      <= ie_d;
      sticky_q  <= sticky_d;
`endif
    end
  end

  always_comb begin
    rdata_o = 8'h00;
    case (offset_i)
      OFF_CLK_DIV:  rdata_o = {3'b000, cdiv_sh_q};
      OFF_PERIOD_L: rdata_o = per_ext[7:0];
      OFF_PERIOD_H: rdata_o = per_ext[15:8];
      OFF_WIDTH_L:  rdata_o = wid_ext[7:0];
      OFF_WIDTH_H:  rdata_o = wid_ext[15:8];
      OFF_COUNT_L:  rdata_o = cnt_ext[7:0];
      OFF_COUNT_H:  rdata_o = cnt_ext[15:8];
      OFF_CTRL:     rdata_o = {5'b00000, ie_bit, 1'b0, run_q};
      OFF_CDONE_L:  rdata_o = cd_ext[7:0];
      OFF_CDONE_H:  rdata_o = cd_ext[15:8];
      OFF_STATUS:   rdata_o = {5'b00000, (state_q == CM_PENDING), sticky_bit, done_q};
      default:      rdata_o = 8'h00;
    endcase
  end

  assign clk_div_o = cdiv_lv_q;
  assign period_o  = per_lv_q;
  assign width_o   = wid_lv_q;
  assign count_o   = cnt_lv_q;
  assign run_o     = run_q;

endmodule

// File: rtl/ppt_regfile.sv
// Multi-channel PPT register file: channel decode, read mux, RUN strap init, irq.
// Optional interrupt support is enabled by defining PPT_REGFILE_IRQ_EN.
module ppt_regfile
  import ppt_regfile_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int PW       = 14,
  parameter int CW       = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [7:0]             address,
  input  logic [7:0]             data_in,
  output logic [7:0]             data_out,
  input  logic                   write_enable,
  input  logic                   run_on_reset,
  output logic [5*CHANNELS-1:0]  clk_div,
  output logic [PW*CHANNELS-1:0] period,
  output logic [PW*CHANNELS-1:0] width,
  output logic [CW*CHANNELS-1:0] count,
  output logic [CHANNELS-1:0]    run_ppt,
  input  logic [CW*CHANNELS-1:0] count_done,
  input  logic [CHANNELS-1:0]    done,
  output logic                   irq
);

  init_state_t init_q, init_d;
  logic        init_load;
  logic        irq_q;
  logic [7:0]  rdata_ch [CHANNELS];
  logic [CHANNELS-1:0] irq_ch;

  // RUN strap loads on the first idle cycle; any write defers it by a cycle.
  assign init_load = (init_q == INIT_S) && !write_enable;

  always_comb begin
    init_d = init_q;
    if (init_load) init_d = READY_S;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      init_q <= INIT_S;
      irq_q  <= 1'b0;
    end else begin
      init_q <= init_d;
      irq_q  <= |irq_ch;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    ppt_regfile_channel #(
      .PW(PW),
      .CW(CW)
    ) u_ch (
      .clk          (clk),
      .rstn         (rstn),
      .offset_i     (address[3:0]),
      .wr_i         (write_enable && (address[7:4] == 4'(gi))),
      .wdata_i      (data_in),
      .init_load_i  (init_load),
      .run_init_i   (run_on_reset),
      .count_done_i (count_done[gi*CW +: CW]),
      .done_i       (done[gi]),
      .rdata_o      (rdata_ch[gi]),
      .clk_div_o    (clk_div[gi*5 +: 5]),
      .period_o     (period[gi*PW +: PW]),
      .width_o      (width[gi*PW +: PW]),
      .count_o      (count[gi*CW +: CW]),
      .run_o        (run_ppt[gi]),
      .irq_o        (irq_ch[gi])
    );
  end

  always_comb begin
    data_out = 8'h00;
    for (int i = 0; i < CHANNELS; i++) begin
      if (address[7:4] == 4'(i)) data_out = rdata_ch[i];
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_ppt_regfile.sv
// Self-checking bench for ppt_regfile: register map, deferred commit, RUN strap, irq.
module tb_ppt_regfile;
  localparam int CHANNELS = 2;
  localparam int PW = 14;
  localparam int CW = 8;
  localparam logic [7:0] PH_MASK = 8'((1 << (PW - 8)) - 1);
  localparam logic [7:0] CH_MASK = 8'((1 << (CW - 8)) - 1);
  localparam int P0_A = (int'(PH_MASK) << 8) | 'h80;
  localparam int P0_B = (int'(PH_MASK) << 8) | 'h33;
  localparam int CNT0 = (int'(CH_MASK) << 8) | 16;

  logic clk = 1'b0;
  logic rstn;
  logic [7:0] address, data_in, data_out;
  logic write_enable, run_on_reset, irq;
  logic [5*CHANNELS-1:0]  clk_div;
  logic [PW*CHANNELS-1:0] period, width;
  logic [CW*CHANNELS-1:0] count, count_done;
  logic [CHANNELS-1:0]    run_ppt, done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[$];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] exp;
  } sb_t;
  sb_t sb[$];

  ppt_regfile #(.CHANNELS(CHANNELS), .PW(PW), .CW(CW)) dut (
    .clk(clk), .rstn(rstn), .address(address), .data_in(data_in),
    .data_out(data_out), .write_enable(write_enable), .run_on_reset(run_on_reset),
    .clk_div(clk_div), .period(period), .width(width), .count(count),
    .run_ppt(run_ppt), .count_done(count_done), .done(done), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a;
    data_in = d;
    write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
    $display("wr addr=%h data=%h", a, d);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] e);
    sb_t t;
    @(negedge clk);
    address = a;
    write_enable = 1'b0;
    sb.push_back('{a, e});
    #1;
    t = sb.pop_front();
    $display("rd addr=%h data=%h", t.addr, data_out);
    checks++;
    if (data_out !== t.exp) begin
      errors++;
      $display("FAIL rd_%h actual=%h required=%h", t.addr, data_out, t.exp);
    end
  endtask

  initial begin
    logic [7:0] rst_exp [16];
    logic [7:0] stat_done_exp;
    rstn = 1'b0; address = 8'h00; data_in = 8'h00; write_enable = 1'b0;
    run_on_reset = 1'b0; count_done = '0; done = '0;
    for (int i = 0; i < 16; i++) rst_exp[i] = 8'h00;
    rst_exp[0] = 8'h09; rst_exp[1] = 8'h80; rst_exp[3] = 8'h01; rst_exp[5] = 8'h10;
`ifdef PPT_REGFILE_IRQ_EN
    stat_done_exp = 8'h03;
`else
    stat_done_exp = 8'h01;
`endif

    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    for (int c = 0; c < CHANNELS; c++) begin
      chk("rst_clk_div", 32'(clk_div[c*5 +: 5]), 32'd9);
      chk("rst_period", 32'(period[c*PW +: PW]), 32'd128);
      chk("rst_width", 32'(width[c*PW +: PW]), 32'd1);
      chk("rst_count", 32'(count[c*CW +: CW]), 32'd16);
    end
    chk("rst_run", 32'(run_ppt), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);

    // Reset readback table, then write/readback table.
    for (int c = 0; c < CHANNELS; c++)
      for (int o = 0; o < 16; o++)
        vecs.push_back('{1'b0, {4'(c), 4'(o)}, 8'h00, rst_exp[o]});
    vecs.push_back('{1'b0, 8'hF0, 8'h00, 8'h00});
    vecs.push_back('{1'b1, 8'h00, 8'hFF, 8'h1F});
    vecs.push_back('{1'b1, 8'h02, 8'hFF, PH_MASK});
    vecs.push_back('{1'b1, 8'h06, 8'hFF, CH_MASK});
    vecs.push_back('{1'b1, 8'h15, 8'h22, 8'h22});
    vecs.push_back('{1'b1, 8'h08, 8'hFF, 8'h00});
    vecs.push_back('{1'b1, 8'h0B, 8'hFF, 8'h00});
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].we) wr(vecs[i].addr, vecs[i].data);
      rd(vecs[i].addr, vecs[i].exp);
    end

    // Commit on an idle channel.
    wr(8'h11, 8'h40);
    wr(8'h12, 8'h01);
    chk("ch1_period_shadowed", 32'(period[PW +: PW]), 32'd128);
    wr(8'h17, 8'h02);
    #1 chk("ch1_period_pre_commit", 32'(period[PW +: PW]), 32'd128);
    @(negedge clk);
    #1 chk("ch1_period_commit", 32'(period[PW +: PW]), 32'h140);
    chk("ch0_period_untouched", 32'(period[0 +: PW]), 32'd128);
    rd(8'h1A, 8'h00);
    rd(8'h17, 8'h00);

    // Commit deferred while running until done.
    wr(8'h07, 8'h01);
    #1 chk("ch0_run", 32'(run_ppt), 32'd1);
    wr(8'h03, 8'h05);
    wr(8'h07, 8'h03);
    #1 chk("ch0_width_hold", 32'(width[0 +: PW]), 32'd1);
    rd(8'h0A, 8'h04);
    chk("ch0_width_hold2", 32'(width[0 +: PW]), 32'd1);
    done[0] = 1'b1;
    @(negedge clk);
    #1 chk("ch0_width_commit", 32'(width[0 +: PW]), 32'd5);
    chk("ch0_clk_div_commit", 32'(clk_div[0 +: 5]), 32'h1F);
    chk("ch0_period_commit", 32'(period[0 +: PW]), 32'(P0_A));
    chk("ch0_count_commit", 32'(count[0 +: CW]), 32'(CNT0));
    rd(8'h0A, stat_done_exp);
    done[0] = 1'b0;
    wr(8'h0A, 8'h02);
    chk("irq_ie_off", 32'(irq), 32'd0);

    // RUN cleared while pending releases the commit one cycle later.
    wr(8'h01, 8'h33);
    wr(8'h07, 8'h03);
    @(negedge clk);
    #1 chk("ch0_pend_hold", 32'(period[0 +: PW]), 32'(P0_A));
    rd(8'h0A, 8'h04);
    wr(8'h07, 8'h00);
    #1 chk("ch0_run_off_hold", 32'(period[0 +: PW]), 32'(P0_A));
    @(negedge clk);
    #1 chk("ch0_run_off_commit", 32'(period[0 +: PW]), 32'(P0_B));
    rd(8'h0A, 8'h00);

    // COUNT_DONE readback lags the input by one cycle.
    @(negedge clk);
    count_done[CW +: 8] = 8'hA5;
    address = 8'h18;
    #1 chk("cdone_lag", 32'(data_out), 32'h00);
    @(negedge clk);
    #1 chk("cdone_capture", 32'(data_out), 32'hA5);

    // Interrupt path.
    wr(8'h17, 8'h04);
`ifdef PPT_REGFILE_IRQ_EN
    rd(8'h17, 8'h04);
    done[1] = 1'b1;
    @(negedge clk);
    #1 chk("irq_lag", 32'(irq), 32'd0);
    @(negedge clk);
    #1 chk("irq_set", 32'(irq), 32'd1);
    rd(8'h1A, 8'h03);
    done[1] = 1'b0;
    @(negedge clk);
    address = 8'h1A; data_in = 8'h02; write_enable = 1'b1; done[1] = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
    rd(8'h1A, 8'h03);
    chk("irq_set_beats_clear", 32'(irq), 32'd1);
    done[1] = 1'b0;
    wr(8'h1A, 8'h02);
    #1 chk("irq_clear_lag", 32'(irq), 32'd1);
    @(negedge clk);
    #1 chk("irq_cleared", 32'(irq), 32'd0);
    rd(8'h1A, 8'h00);
`else
    rd(8'h17, 8'h00);
    done[1] = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk("irq_tied", 32'(irq), 32'd0);
    rd(8'h1A, 8'h01);
    done[1] = 1'b0;
`endif

    // Out-of-range channel index.
    wr(8'hF0, 8'hFF);
    wr(8'hF7, 8'h03);
    #1 chk("bad_ch_run", 32'(run_ppt), 32'd0);
    rd(8'hF0, 8'h00);
    rd(8'hF7, 8'h00);
    rd(8'h00, 8'h1F);

    // RUN strap after reset release, then with a write in the first cycle.
    @(negedge clk);
    rstn = 1'b0; run_on_reset = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    #1 chk("strap_pre", 32'(run_ppt), 32'd0);
    @(negedge clk);
    #1 chk("strap_load", 32'(run_ppt), 32'd3);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    address = 8'h00; data_in = 8'h0C; write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
    #1 chk("strap_deferred", 32'(run_ppt), 32'd0);
    chk("strap_live_clk_div", 32'(clk_div[0 +: 5]), 32'd9);
    @(negedge clk);
    #1 chk("strap_retry", 32'(run_ppt), 32'd3);
    rd(8'h00, 8'h0C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ppt_regfile.md
# ppt_regfile

Multi-channel, parametrised register file between the I2C slave register interface and an array of PPT pulse-train controllers. It generalises the single-channel PPT register map to CHANNELS independent channels with configurable period/width/count widths. Configuration writes land in shadow registers and reach the controllers only on an explicit per-channel commit, which is deferred while the channel is mid-run. Optional sticky DONE flags with interrupt output allow the host to avoid polling.

## Interface
- CHANNELS, 2, number of PPT channels, 1..15
- PW, 14, period/width bit width, 9..16
- CW, 8, count and count_done bit width, 8..16
---
- clk  in  1  system clock
- rstn  in  1  asynchronous, active-low reset
- address  in  8  [7:4] channel index, [3:0] register offset
- data_in  in  8  write data
- data_out  out  8  read data, combinational on address
- write_enable  in  1  single-cycle write strobe
- run_on_reset  in  1  strap: initial RUN value for all channels
- clk_div  out  5*CHANNELS  live clock divider per channel
- period  out  PW*CHANNELS  live period per channel
- width  out  PW*CHANNELS  live pulse width per channel
- count  out  CW*CHANNELS  live firing count per channel
- run_ppt  out  CHANNELS  live RUN per channel
- count_done  in  CW*CHANNELS  firings completed, from controllers
- done  in  CHANNELS  controller finished, level
- irq  out  1  OR of enabled sticky DONE flags

## Operation
- Per-channel offsets: 0 CLK_DIV[4:0]; 1 PERIOD_L; 2 PERIOD_H[PW-9:0]; 3 WIDTH_L; 4 WIDTH_H[PW-9:0]; 5 COUNT_L; 6 COUNT_H[CW-9:0] (reads 0, write ignored when CW=8); 7 CTRL; 8 COUNT_DONE_L; 9 COUNT_DONE_H; A STATUS; B..F read 0.
- Offsets 0-6 write shadow registers; reads return shadow. Unused upper bits read 0.
- CTRL: bit0 RUN (live, not shadowed, read/write); bit1 COMMIT (write-1 sets pending, reads 0); bit2 IE (interrupt enable, macro only).
- STATUS: bit0 DONE live; bit1 DONE_STICKY (W1C, macro only); bit2 PENDING.
- Channel index >= CHANNELS: writes ignored, reads 0.
- Per-channel commit FSM: IDLE -> PENDING on COMMIT write; PENDING -> IDLE with shadow->live copy in the first cycle where RUN live = 0 or done = 1. COMMIT written in PENDING: stays PENDING.
- COUNT_DONE and DONE sampled every cycle, independent of write_enable.
- Init FSM: INIT -> READY; in the first cycle after reset release with write_enable low, all RUN <= run_on_reset. A write in that cycle takes priority; init then retries next non-write cycle.

## Timing
- Reset: shadow and live CLK_DIV=9, PERIOD=128, WIDTH=1, COUNT=16; RUN=0; IE=0; COUNT_DONE=0; DONE=0; sticky=0; PENDING=0; irq=0; data_out follows address.
- Write: register updated at the clk edge sampling write_enable; readable next cycle.
- Commit on idle channel: live outputs change 1 cycle after the COMMIT write edge. Running channel: 1 cycle after done first seen high.
- RUN write 0 while PENDING: commit applies the following cycle.
- Status: COUNT_DONE/DONE readback lags inputs by 1 cycle.
- Sticky set on done rising edge (registered done_q); set beats simultaneous W1C clear. irq registered, 1 cycle after sticky.

## Configuration
- PPT_REGFILE_IRQ_EN defined: IE bit, DONE_STICKY, done edge detector and irq implemented.
- Undefined: CTRL bit2 and STATUS bit1 read 0, writes ignored; irq tied 0; port list unchanged.

## Structure
- Package ppt_regfile_pkg: register offset constants, CTRL/STATUS bit positions, reset default constants.
- Sub-module ppt_regfile_channel: shadow/live registers, commit FSM, status capture and sticky logic for one channel; top generates CHANNELS instances, decodes channel index, muxes data_out, runs init FSM, ORs irq.

## Test plan
- Reset, read all offsets ch0/ch1 -> CLK_DIV 0x09, PERIOD_L 0x80, WIDTH_L 0x01, COUNT_L 0x10, others 0; outputs at defaults.
- RUN=0 ch1: write PERIOD_L 0x40, PERIOD_H 0x01 -> period ch1 still 128; write CTRL 0x02 -> period ch1 = 0x140 next cycle, PENDING 0.
- ch0 RUN=1, done=0: write WIDTH_L 0x05 + COMMIT -> PENDING 1, width unchanged; raise done -> width 5 next cycle, PENDING 0.
- run_on_reset=1, release reset -> run_ppt all 1 after one cycle; repeat with write on first cycle -> RUN set one cycle later.
- IRQ_EN: IE=1, done ch1 rises -> sticky 1, irq 1; W1C on same cycle as second rising edge -> sticky stays 1; clean W1C -> irq 0.
- address 0xF0 write 0xFF -> no state change; read returns 0.
